// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message packer.
//   state_e       : packer FSM states
//   md5_buf_t     : 64-byte block buffer, element k is message byte k
//   md5_put_len() : writes a 64-bit bit length little-endian into bytes 56..63
package md5_pkg;

  typedef enum logic [1:0] {StFill, StFinal, StEmit, StTail} state_e;

  localparam int unsigned MD5_BLOCK_BYTES = 64;
  localparam int unsigned MD5_LEN_OFFSET  = 56;
  localparam logic [7:0]  MD5_PAD_MARKER  = 8'h80;

  typedef logic [MD5_BLOCK_BYTES-1:0][7:0] md5_buf_t;

  function automatic md5_buf_t md5_put_len(input md5_buf_t b, input logic [63:0] len);
    md5_buf_t r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      r[MD5_LEN_OFFSET + i] = len[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/md5_msg_packer.sv
// Byte-stream to 512-bit block packer with MD5 padding, feeding md5_core.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_data/in_valid/in_ready   : message byte stream
//   in_last                     : final beat of the message
//   in_empty                    : with in_last, beat carries no data byte
//   blk_data                    : block, byte k in bits [8k:8k+7]
//   blk_first/blk_last          : first / final block of the message
//   blk_valid/blk_ready         : block handshake
//   busy                        : anything other than FILL with an empty buffer
module md5_msg_packer
  import md5_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [0:511] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         busy
);

  state_e           state_q, state_d;
  md5_buf_t         buf_q, buf_d;
  logic [6:0]       n_q, n_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             tail_q, tail_d;
  logic             marker_q, marker_d;
  logic             final_q, final_d;
  logic [63:0]      len64;
  logic             has_byte;

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = len_q;
  end

  // in_empty only counts together with in_last.
  assign has_byte = !(in_last && in_empty);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    n_d      = n_q;
    len_d    = len_q;
    first_d  = first_q;
    tail_d   = tail_q;
    marker_d = marker_q;
    final_d  = final_q;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          if (has_byte) begin
            buf_d[n_q[5:0]] = in_data;
            n_d   = n_q + 7'd1;
            len_d = len_q + LEN_W'(8);
          end
          if (in_last) begin
            final_d = 1'b1;
            state_d = StFinal;
          end else if (n_q == 7'd63) begin
            final_d = 1'b0;
            state_d = StEmit;
          end
        end
      end
      StFinal: begin
        if (n_q <= 7'd55) begin
          buf_d[n_q[5:0]] = MD5_PAD_MARKER;
          buf_d  = md5_put_len(buf_d, len64);
          tail_d = 1'b0;
        end else if (n_q <= 7'd63) begin
          // No room for the length: marker here, length in a tail block.
          buf_d[n_q[5:0]] = MD5_PAD_MARKER;
          tail_d   = 1'b1;
          marker_d = 1'b0;
        end else begin
          tail_d   = 1'b1;
          marker_d = 1'b1;
        end
        state_d = StEmit;
      end
      StEmit: begin
        if (blk_ready) begin
          buf_d   = '0;
          n_d     = '0;
          first_d = 1'b0;
          if (tail_q) begin
            state_d = StTail;
          end else if (final_q) begin
            first_d = 1'b1;
            len_d   = '0;
            final_d = 1'b0;
            state_d = StFill;
          end else begin
            state_d = StFill;
          end
        end
      end
      StTail: begin
        buf_d    = '0;
        buf_d[0] = marker_q ? MD5_PAD_MARKER : 8'h00;
        buf_d    = md5_put_len(buf_d, len64);
        tail_d   = 1'b0;
        state_d  = StEmit;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      buf_q    <= '0;
      n_q      <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      tail_q   <= 1'b0;
      marker_q <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      n_q      <= n_d;
      len_q    <= len_d;
      first_q  <= first_d;
      tail_q   <= tail_d;
      marker_q <= marker_d;
      final_q  <= final_d;
    end
  end

  // Outputs are forced low while rst is high, even before the first reset edge.
  always_comb begin
    in_ready  = !rst && (state_q == StFill);
    blk_valid = !rst && (state_q == StEmit);
    blk_first = blk_valid && first_q;
    blk_last  = blk_valid && final_q && !tail_q;
    busy      = !rst && ((state_q != StFill) || (n_q != 7'd0));
    blk_data  = '0;
    if (!rst) begin
      for (int k = 0; k < 64; k++) begin
        blk_data[8*k +: 8] = buf_q[k];
      end
    end
  end

endmodule

// File: tb/tb_md5_msg_packer.sv
module tb_md5_msg_packer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [0:511] data;
    logic         first;
    logic         last;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [0:511] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int stall_mode = 0;  // -1: random 0..3 cycles per block, else fixed stall
  int stall_cur = 0;
  int stall_cnt = 0;

  blk_t exp_q[$];

  always #5 clk = ~clk;

  md5_msg_packer #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .busy      (busy)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void chk_blk(input string name, input logic [0:511] act,
                                  input logic [0:511] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Reference: pad the whole message as a byte array, then slice into blocks.
  function automatic void model_push(input bq_t m);
    bq_t         p;
    logic [63:0] bitlen;
    int          nblk;
    blk_t        b;
    p = m;
    bitlen = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bitlen[8*i +: 8]);
    nblk = p.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      for (int k = 0; k < 64; k++) b.data[8*k +: 8] = p[64*j + k];
      b.first = (j == 0);
      b.last  = (j == nblk - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Monitor / scoreboard.
  logic [0:511] held_data;
  logic         held_first, held_last, held_valid = 1'b0;
  blk_t         got;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_flags", {62'd0, blk_first, blk_last}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_blk("rst_blk_data", blk_data, '0);
        held_valid = 1'b0;
      end else begin
        if (blk_valid) chk("in_ready_while_pending", 64'(in_ready), 64'd0);
        if (held_valid) begin
          chk("stall_valid_held", 64'(blk_valid), 64'd1);
          chk_blk("stall_data_stable", blk_data, held_data);
          chk("stall_flags_stable", {62'd0, blk_first, blk_last},
              {62'd0, held_first, held_last});
        end
        if (blk_valid && blk_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_block: got block first=%0b last=%0b, expected none",
                     blk_first, blk_last);
          end else begin
            got = exp_q.pop_front();
            chk_blk("blk_data", blk_data, got.data);
            chk("blk_first", 64'(blk_first), 64'(got.first));
            chk("blk_last", 64'(blk_last), 64'(got.last));
          end
          held_valid = 1'b0;
        end else if (blk_valid) begin
          held_data  = blk_data;
          held_first = blk_first;
          held_last  = blk_last;
          held_valid = 1'b1;
        end else begin
          held_valid = 1'b0;
        end
      end
    end
  end

  // Consumer: random ready while idle (must be ignored), stall then accept when valid.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!blk_valid) begin
        stall_cnt = 0;
        stall_cur = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
        blk_ready = 1'($urandom_range(0, 1));
      end else if (stall_cnt < stall_cur) begin
        blk_ready = 1'b0;
        stall_cnt++;
      end else begin
        blk_ready = 1'b1;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    bit ok;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    in_empty = e;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 2000 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic idle_gap(input int gap_pct);
    if (int'($urandom_range(0, 99)) < gap_pct) begin
      repeat ($urandom_range(1, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_msg(input bq_t m, input bit empty_tail, input int gap_pct,
                          input bit lat_chk);
    bit et;
    et = empty_tail || (m.size() == 0);
    model_push(m);
    for (int i = 0; i < m.size(); i++) begin
      idle_gap(gap_pct);
      send_beat(m[i], (i == m.size() - 1) && !et, 1'b0);
      if (i == 0 && m.size() > 1) chk("busy_filling", 64'(busy), 64'd1);
      if (lat_chk && ((i + 1) % 64 == 0) && (i != m.size() - 1 || et)) begin
        @(negedge clk);
        chk("lat_full_block", 64'(blk_valid), 64'd1);
      end
    end
    if (et) begin
      idle_gap(gap_pct);
      send_beat(8'($urandom), 1'b1, 1'b1);
    end
    if (lat_chk) begin
      @(negedge clk);
      chk("lat_final_cycle", 64'(blk_valid), 64'd0);
      @(negedge clk);
      chk("lat_valid", 64'(blk_valid), 64'd1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || blk_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d blocks outstanding, expected 0", exp_q.size());
    end
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  bq_t   msg;
  string lorem;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    stall_mode = 0;
    send_msg(str2q("Softex"), 1'b0, 0, 1'b1);
    drain();
    send_msg(msg, 1'b1, 0, 1'b1);  // msg is still empty here
    drain();
    send_msg(rand_q(55), 1'b0, 20, 1'b1);
    drain();
    send_msg(rand_q(56), 1'b0, 20, 1'b1);
    drain();
    send_msg(rand_q(64), 1'b0, 20, 1'b1);
    drain();

    stall_mode = 5;
    lorem = {"Lorem ipsum dolor sit amet, consectetur adipiscing elit, sed do eiusmod ",
             "tempor incididunt ut labore et dolore magna aliqua. Ut enim ad minim veniam, ",
             "quis nostrud exercitation ullamco laboris"};
    send_msg(str2q(lorem), 1'b0, 0, 1'b1);
    drain();

    // Abort a message while byte 30 is on the bus.
    stall_mode = 0;
    msg = rand_q(30);
    for (int i = 0; i < 29; i++) send_beat(msg[i], 1'b0, 1'b0);
    in_data  = msg[29];
    in_valid = 1'b1;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    send_msg(str2q("Softex"), 1'b0, 0, 1'b1);
    drain();

    stall_mode = -1;
    for (int r = 0; r < 8; r++) begin
      send_msg(rand_q(int'($urandom_range(0, 200))), 1'($urandom_range(0, 1)), 30, 1'b0);
    end
    send_msg(rand_q(63), 1'b1, 30, 1'b0);
    send_msg(rand_q(128), 1'b1, 30, 1'b0);
    drain();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/md5_msg_packer.md
Name: md5_msg_packer

Overview:
- Upstream stage of md5_core.
- Accepts an arbitrary-length message as a byte stream and assembles 512-bit blocks.
- Inserts MD5 padding in hardware: 0x80 marker, zero fill, 64-bit little-endian bit length.
- Presents each block with a valid/ready handshake, plus first/last flags that map directly onto core start (first) vs resume (subsequent).

Parameters:
LEN_W, 64, width of the internal message bit-length counter; wraps mod 2^LEN_W and is zero-extended into the 64-bit length field when LEN_W<64.

Ports:
clk  input  1  system clock
rst  input  1  reset
in_data  input  8  message byte
in_valid  input  1  in_data/in_last/in_empty qualifier
in_last  input  1  final byte of message
in_empty  input  1  with in_last: no data byte this beat (zero-length tail / empty message)
in_ready  output  1  byte accepted when in_valid & in_ready
blk_data  output  [0:511]  block; byte k occupies bits [8k:8k+7]
blk_first  output  1  first block of a message
blk_last  output  1  final block of a message
blk_valid  output  1  block available
blk_ready  input  1  consumer takes block when blk_valid & blk_ready
busy  output  1  high in any state other than FILL with an empty buffer

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset state and outputs:
  - While rst is high: state FILL, buffer=0, byte count n=0, bit length=0, first_pending=1, tail_pending=0.
  - Outputs while rst is high: in_ready=0, blk_valid=0, blk_first=0, blk_last=0, busy=0, blk_data=0.
- Reset mid-operation discards any partial message and any pending block; no block is emitted for it.
- States: FILL, FINAL, EMIT, TAIL.
- FILL:
  - in_ready=1. Each accepted byte (in_empty=0) is written at index n; n increments; bit length increments by 8.
  - Accept with n becoming 64 and in_last=0 -> EMIT with blk_last=0. blk_valid is high the cycle after acceptance.
  - Accept with in_last=1 -> FINAL. in_empty=1 writes no byte and leaves n and the length unchanged.
- FINAL (one cycle, in_ready=0). Let n = bytes in buffer (0..64):
  - n<=55: byte n=0x80; bytes 56..63 = bit length, little-endian (byte 56 = LSB); tail_pending=0.
  - 56<=n<=63: byte n=0x80, remaining bytes zero; tail_pending=1, tail_marker=0.
  - n==64 (in_last on the 64th byte): buffer unchanged; tail_pending=1, tail_marker=1.
  - Then -> EMIT. blk_valid is high 2 cycles after the last-byte acceptance.
- EMIT:
  - blk_valid=1; blk_first=first_pending; blk_last = in-message-final AND NOT tail_pending.
  - blk_data and both flags are held stable until the handshake.
  - On handshake: clear buffer and n; first_pending=0. Then:
    - if tail_pending -> TAIL;
    - else if the block was final -> FILL, with first_pending=1 and length=0 for the next message;
    - else -> FILL.
- TAIL (one cycle):
  - Buffer = byte 0 is 0x80 if tail_marker else 0x00; bytes 1..55 zero; bytes 56..63 = bit length.
  - tail_pending=0 -> EMIT, with blk_last=1 and blk_first=0.
- Concurrency rules:
  - in_ready=0 in FINAL, EMIT and TAIL. There is no overlap of input acceptance and output hold; this is a single-buffer design.
  - blk_valid never drops without a handshake. blk_ready while blk_valid=0 is ignored.
  - in_valid with in_last=0 and in_empty=1 is illegal; the byte is treated as data (in_empty ignored).
- Length: counts only accepted data bytes × 8, mod 2^LEN_W.

Decomposition:
- Package md5_pkg holds:
  - state encoding (FILL/FINAL/EMIT/TAIL);
  - MD5_BLOCK_BYTES=64, MD5_LEN_OFFSET=56, MD5_PAD_MARKER=8'h80;
  - a function placing a 64-bit length little-endian into bytes 56..63.
- No sub-module; the buffer and byte-write logic stay inline.

Test Plan:
- "Softex" (6 bytes, last on 'x'):
  - one block, first=1, last=1;
  - bytes 0-5 "Softex", byte6=0x80, byte56=0x30, bytes 57-63=0x00;
  - blk_valid 2 cycles after the last acceptance.
- Empty message (single beat in_last=1, in_empty=1):
  - one block, byte0=0x80, all others zero, length=0, first=1, last=1.
- 55-byte and 56-byte messages:
  - 55 bytes -> one block with 0x80 at byte55 and length bytes 56..57 = B8 01.
  - 56 bytes -> block1 (first=1, last=0) with 0x80 at byte56, bytes 57-63 zero; block2 (first=0, last=1) with bytes 0-55 zero and length C0 01.
- 64-byte message:
  - block1 = the raw 64 bytes, last=0;
  - block2 = byte0 0x80, length bytes 56..57 = 00 02, last=1.
- 190-byte message ("Lorem ipsum…laboris") with blk_ready held low 5 cycles on each block:
  - 4 blocks total; blk_data and flags stable throughout each stall; in_ready=0 while blocks are pending;
  - final block length bytes F0 05.
- rst asserted in the middle of byte 30 of a message, then "Softex" sent:
  - no block emitted for the aborted message;
  - the next block is identical to the "Softex" scenario (first=1, length 0x30).
